neuron_mac: RTL and testbench

//  Per-neuron multiply-accumulate stage feeding ReLU. Streams numWeight signed

---
 rtl/neuron_mac.sv | 132 +++++++++++++
 tb/tb_neuron_mac.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: per-neuron multiply-accumulate stage feeding a ReLU.
//
// Streams numWeight signed samples against an internal weight RAM. Products
// are summed at ACCW = 2*dataWidth+IntWidthExtend bits. A bias is added and
// one full-precision sum is emitted per input vector.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (synchronous release expected)
//   w_wen      in   weight RAM write enable
//   w_addr     in   weight write address [addrWidth]
//   w_data     in   weight write data, signed [dataWidth]
//   b_wen      in   bias load enable
//   b_data     in   bias in product format, signed [2*dataWidth]
//   in_valid   in   in_data valid this cycle (no backpressure)
//   in_data    in   signed input sample [dataWidth]
//   sum_out    out  signed sum(in*w)+bias [ACCW], held between pulses
//   sum_valid  out  one-cycle pulse marking a new sum_out
module neuron_mac #(
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4,
  parameter int IntWidthExtend = 10,
  parameter int numWeight      = 784,
  parameter int addrWidth      = 10
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           w_wen,
  input  logic        [addrWidth-1:0]                    w_addr,
  input  logic signed [dataWidth-1:0]                    w_data,
  input  logic                                           b_wen,
  input  logic signed [2*dataWidth-1:0]                  b_data,
  input  logic                                           in_valid,
  input  logic signed [dataWidth-1:0]                    in_data,
  output logic signed [2*dataWidth+IntWidthExtend-1:0]   sum_out,
  output logic                                           sum_valid
);

  localparam int PW   = 2 * dataWidth;
  localparam int ACCW = 2 * dataWidth + IntWidthExtend;
  localparam logic [addrWidth-1:0] LAST_ADDR = addrWidth'(numWeight - 1);

  // Parameter sanity: the guard bits only prevent overflow while the vector
  // length stays within 2**IntWidthExtend, and the address must cover the RAM.
  if (numWeight > (1 << IntWidthExtend)) begin : g_chk_guard
    $error("neuron_mac: numWeight exceeds 2**IntWidthExtend");
  end
  if ((1 << addrWidth) < numWeight) begin : g_chk_addr
    $error("neuron_mac: addrWidth too small for numWeight");
  end
  if (weightIntWidth > dataWidth) begin : g_chk_fmt
    $error("neuron_mac: weightIntWidth exceeds dataWidth");
  end

  // Weight storage. Not reset; written only through w_wen.
  logic signed [dataWidth-1:0] weight_mem [numWeight];

  logic        [addrWidth-1:0] r_addr;
  logic signed [dataWidth-1:0] in_r;
  logic signed [dataWidth-1:0] w_r;
  logic                        v1;
  logic                        last1;
  logic signed [PW-1:0]        prod_r;
  logic                        v2;
  logic                        last2;
  logic signed [ACCW-1:0]      acc;
  logic signed [PW-1:0]        bias_r;

  logic signed [ACCW-1:0]      prod_ext;
  logic signed [ACCW-1:0]      bias_ext;

  // Signed size casts sign-extend into the accumulator width.
  assign prod_ext = ACCW'(prod_r);
  assign bias_ext = ACCW'(bias_r);

  // Write port. The read in the pipeline below samples the array at the same
  // edge, so a same-address write/read returns the old word.
  always_ff @(posedge clk) begin
    if (w_wen) begin
      weight_mem[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      in_r      <= '0;
      w_r       <= '0;
      v1        <= 1'b0;
      last1     <= 1'b0;
      prod_r    <= '0;
      v2        <= 1'b0;
      last2     <= 1'b0;
      acc       <= '0;
      bias_r    <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      if (b_wen) begin
        bias_r <= b_data;
      end

      // Stage 1: capture sample and its weight; bubbles leave r_addr alone.
      v1 <= in_valid;
      if (in_valid) begin
        in_r   <= in_data;
        w_r    <= weight_mem[r_addr];
        last1  <= (r_addr == LAST_ADDR);
        r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
      end

      // Stage 2: full-precision signed product.
      prod_r <= PW'(in_r) * PW'(w_r);
      v2     <= v1;
      last2  <= last1;

      // Stage 3: accumulate, or close the vector. Clearing acc here lets the
      // next vector's first product accumulate on the very next edge.
      sum_valid <= 1'b0;
      if (v2) begin
        if (last2) begin
          sum_out   <= acc + prod_ext + bias_ext;
          sum_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc + prod_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
module tb_neuron_mac;

  localparam int DW   = 16;
  localparam int IE   = 10;
  localparam int NW   = 4;
  localparam int AW   = 2;
  localparam int ACCW = 2 * DW + IE;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   w_wen = 1'b0;
  logic        [AW-1:0]   w_addr = '0;
  logic signed [DW-1:0]   w_data = '0;
  logic                   b_wen = 1'b0;
  logic signed [2*DW-1:0] b_data = '0;
  logic                   in_valid = 1'b0;
  logic signed [DW-1:0]   in_data = '0;
  logic signed [ACCW-1:0] sum_out;
  logic                   sum_valid;

  always #5 clk = ~clk;

  neuron_mac #(
    .dataWidth(DW), .weightIntWidth(4), .IntWidthExtend(IE),
    .numWeight(NW), .addrWidth(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .w_wen(w_wen), .w_addr(w_addr), .w_data(w_data),
    .b_wen(b_wen), .b_data(b_data),
    .in_valid(in_valid), .in_data(in_data),
    .sum_out(sum_out), .sum_valid(sum_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_in_cyc = 0;

  // Reference model: dot product of the accepted samples with the weight
  // table as it stood when each sample was read, plus bias, due 3 cycles
  // after the final sample of the vector.
  typedef struct {
    int     due;
    longint val;
  } pend_t;
  pend_t pq[$];
  logic signed [DW-1:0]   wm [NW];
  logic signed [2*DW-1:0] bias_m = '0;
  longint acc_m = 0;
  int     idx_m = 0;
  longint held_m = 0;

  int     pulse_cyc[$];
  longint pulse_val[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic v, input logic signed [DW-1:0] d,
                      input logic we = 1'b0, input logic [AW-1:0] wa = '0,
                      input logic signed [DW-1:0] wd = '0,
                      input logic be = 1'b0, input logic signed [2*DW-1:0] bd = '0);
    logic exp_v;
    in_valid = v; in_data = d;
    w_wen = we; w_addr = wa; w_data = wd;
    b_wen = be; b_data = bd;
    if (v) begin
      acc_m += longint'(d) * longint'(wm[idx_m]);
      if (idx_m == NW - 1) begin
        pend_t p;
        p.due = cyc + 3;
        p.val = acc_m + longint'(be ? bd : bias_m);
        pq.push_back(p);
        acc_m = 0;
        idx_m = 0;
      end else begin
        idx_m++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (we) wm[wa] = wd;
    if (be) bias_m = bd;
    exp_v = (pq.size() > 0) && (pq[0].due == cyc);
    if (sum_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_val.push_back(longint'(sum_out));
    end
    if (exp_v) begin
      held_m = pq[0].val;
      void'(pq.pop_front());
    end
    chk("sum_valid", longint'(sum_valid), longint'(exp_v));
    chk("sum_out", longint'(sum_out), held_m);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0);
  endtask

  task automatic load_w(input logic signed [DW-1:0] a, b, c, d);
    tick(1'b0, '0, 1'b1, 2'd0, a);
    tick(1'b0, '0, 1'b1, 2'd1, b);
    tick(1'b0, '0, 1'b1, 2'd2, c);
    tick(1'b0, '0, 1'b1, 2'd3, d);
  endtask

  task automatic set_bias(input logic signed [2*DW-1:0] bd);
    tick(1'b0, '0, 1'b0, '0, '0, 1'b1, bd);
  endtask

  task automatic vec(input logic signed [DW-1:0] a, b, c, d, input int gap_max);
    logic signed [DW-1:0] x [NW];
    x[0] = a; x[1] = b; x[2] = c; x[3] = d;
    for (int i = 0; i < NW; i++) begin
      repeat ($urandom_range(gap_max, 0)) tick(1'b0, '0);
      if (i == NW - 1) last_in_cyc = cyc;
      tick(1'b1, x[i]);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; w_wen = 1'b0; b_wen = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_sum_out", longint'(sum_out), 0);
    chk("rst_sum_valid", longint'(sum_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pq.delete();
    acc_m = 0; idx_m = 0; bias_m = '0; held_m = 0;
  endtask

  initial begin
    do_reset();

    // 1: basic vector
    load_w(16'sd1, 16'sd2, 16'sd3, 16'sd4);
    set_bias(32'sd10);
    pulse_cyc.delete(); pulse_val.delete();
    vec(16'sd5, 16'sd6, 16'sd7, 16'sd8, 0);
    idle(5);
    chk("t1_npulse", longint'(pulse_cyc.size()), 1);
    if (pulse_cyc.size() >= 1) begin
      chk("t1_val", pulse_val[0], 80);
      chk("t1_latency", longint'(pulse_cyc[0] - last_in_cyc), 3);
    end

    // 2: extreme negative products, sign extension to 42 bits
    load_w(-16'sd1, -16'sd1, -16'sd1, -16'sd1);
    set_bias(32'sd0);
    pulse_cyc.delete(); pulse_val.delete();
    vec(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 0);
    idle(5);
    chk("t2_npulse", longint'(pulse_cyc.size()), 1);
    if (pulse_cyc.size() >= 1) chk("t2_val", pulse_val[0], -131068);

    // 3: back-to-back vectors
    load_w(16'sd1, 16'sd2, 16'sd3, 16'sd4);
    set_bias(32'sd10);
    pulse_cyc.delete(); pulse_val.delete();
    vec(16'sd5, 16'sd6, 16'sd7, 16'sd8, 0);
    vec(16'sd1, 16'sd1, 16'sd1, 16'sd1, 0);
    idle(5);
    chk("t3_npulse", longint'(pulse_cyc.size()), 2);
    if (pulse_cyc.size() >= 2) begin
      chk("t3_spacing", longint'(pulse_cyc[1] - pulse_cyc[0]), 4);
      chk("t3_val0", pulse_val[0], 80);
      chk("t3_val1", pulse_val[1], 20);
    end

    // 4: random bubbles inside the vector
    pulse_cyc.delete(); pulse_val.delete();
    vec(16'sd5, 16'sd6, 16'sd7, 16'sd8, 3);
    idle(5);
    chk("t4_npulse", longint'(pulse_cyc.size()), 1);
    if (pulse_cyc.size() >= 1) begin
      chk("t4_val", pulse_val[0], 80);
      chk("t4_latency", longint'(pulse_cyc[0] - last_in_cyc), 3);
    end

    // 5: reset mid-vector discards the partial sum
    pulse_cyc.delete(); pulse_val.delete();
    tick(1'b1, 16'sd5);
    tick(1'b1, 16'sd6);
    do_reset();
    set_bias(32'sd10);
    vec(16'sd5, 16'sd6, 16'sd7, 16'sd8, 0);
    idle(5);
    chk("t5_npulse", longint'(pulse_cyc.size()), 1);
    if (pulse_cyc.size() >= 1) chk("t5_val", pulse_val[0], 80);

    // 6: weight write colliding with its own read returns old data
    pulse_cyc.delete(); pulse_val.delete();
    tick(1'b1, 16'sd5);
    tick(1'b1, 16'sd6);
    tick(1'b1, 16'sd7, 1'b1, 2'd2, 16'sd100);
    tick(1'b1, 16'sd8);
    vec(16'sd5, 16'sd6, 16'sd7, 16'sd8, 0);
    idle(5);
    chk("t6_npulse", longint'(pulse_cyc.size()), 2);
    if (pulse_cyc.size() >= 2) begin
      chk("t6_val_old", pulse_val[0], 80);
      chk("t6_val_new", pulse_val[1], 759);
    end

    // Randomized vectors, weights and biases against the model
    for (int n = 0; n < 12; n++) begin
      load_w(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      set_bias((2*DW)'($urandom));
      for (int k = 0; k < 3; k++) begin
        vec(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), 2);
      end
      idle(2);
    end

    idle(5);
    chk("drained", longint'(pq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
